// File: rtl/arb4way16_pkg.sv
// Shared definitions for the Hack bus controllers: FSM state encoding and
// requester indices used by the arbiter and its data mux.
package arb4way16_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

endpackage

// File: rtl/mux4way16.sv
// 4:1 mux of 16-bit words; the arbiter drives sel with the granted requester.
module mux4way16
  import arb4way16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  always_comb begin
    out = a;
    case (sel)
      REQ_A:   out = a;
      REQ_B:   out = b;
      REQ_C:   out = c;
      REQ_D:   out = d;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/arb4way16.sv
// Round-robin arbiter sharing one 16-bit sink among four requesters, with
// bounded locked bursts and a mandatory idle cycle between grants.
module arb4way16
  import arb4way16_pkg::*;
#(
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  lock,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  input  logic [15:0] data_c,
  input  logic [15:0] data_d,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  state_t           state;
  logic [1:0]       last;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       winner;
  logic             beat;
  logic             rel_now;

  // First requester set when scanning last+1, last+2, last+3, last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] prev);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = prev;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = prev + 2'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign winner    = rr_pick(req, last);
  assign busy      = (state == ST_BUSY);
  assign out_valid = busy && req[sel];
  assign beat      = out_valid && out_ready;

  // An abandoned grant releases without a beat; otherwise release on the
  // final beat of a burst or on any unlocked beat.
  assign rel_now = busy && (!req[sel] ||
                   (beat && (!lock[sel] || beat_cnt == CNT_W'(MAX_BEATS - 1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= 4'b0000;
      sel      <= REQ_A;
      last     <= REQ_D;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt      <= 4'b0001 << winner;
            sel      <= winner;
            beat_cnt <= '0;
            state    <= ST_BUSY;
          end else begin
            gnt <= 4'b0000;
          end
        end
        ST_BUSY: begin
          if (rel_now) begin
            last     <= sel;
            gnt      <= 4'b0000;
            beat_cnt <= '0;
            state    <= ST_IDLE;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mux4way16 u_mux (
    .a   (data_a),
    .b   (data_b),
    .c   (data_c),
    .d   (data_d),
    .sel (sel),
    .out (out_data)
  );

endmodule

// File: tb/tb_arb4way16.sv
// Self-checking bench for arb4way16: directed scenarios plus randomized
// traffic compared against a grant-level reference model.
module tb_arb4way16;

  localparam int MAX_BEATS = 8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [15:0] data_a, data_b, data_c, data_d;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int tests_run;
  int tests_failed;

  // Reference model: who owns the sink (-1 when nobody), who released last,
  // which requester the mux points at, and beats taken in the current grant.
  int m_owner;
  int m_last;
  int m_sel;
  int m_beats;

  arb4way16 #(.MAX_BEATS(MAX_BEATS), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .data_d    (data_d),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] modelData(input int s);
    case (s)
      0:       return data_a;
      1:       return data_b;
      2:       return data_c;
      default: return data_d;
    endcase
  endfunction

  task automatic modelReset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_beats = 0;
  endtask

  task automatic modelRelease();
    m_last  = m_owner;
    m_owner = -1;
    m_beats = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    if (m_owner < 0) begin
      if (req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_owner < 0 && req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
        end
        m_sel   = m_owner;
        m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      modelRelease();
    end else if (out_ready) begin
      m_beats++;
      if (!lock[m_owner] || m_beats == MAX_BEATS) modelRelease();
    end
  endtask

  task automatic checkModel();
    logic [31:0] exp_gnt;
    logic        exp_valid;
    exp_gnt   = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    exp_valid = 1'b0;
    if (m_owner >= 0) exp_valid = req[m_owner];
    checkOutput("gnt", {28'd0, gnt}, exp_gnt);
    checkOutput("sel", {30'd0, sel}, 32'(m_sel));
    checkOutput("busy", {31'd0, busy}, {31'd0, (m_owner >= 0)});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    checkOutput("out_data", {16'd0, out_data}, {16'd0, modelData(m_sel)});
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    req       = r;
    lock      = l;
    out_ready = rdy;
    #1;
    checkModel();
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] grant_seen[$];
  logic [3:0] order_exp[5];
  int         beats_seen;
  logic [3:0] cur_req;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req          = 4'b0000;
    lock         = 4'b0000;
    out_ready    = 1'b0;
    data_a       = 16'h0000;
    data_b       = 16'h1111;
    data_c       = 16'h2222;
    data_d       = 16'h3333;
    modelReset();
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("reset_sel", {30'd0, sel}, 32'd0);
    checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    stepClock();

    // Single unlocked beat from A.
    data_a = 16'h1234;
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("t1_idle_gnt", {28'd0, gnt}, 32'd0);
    stepClock();
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("t1_gnt", {28'd0, gnt}, 32'h1);
    checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t1_data", {16'd0, out_data}, 32'h1234);
    stepClock();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t1_after_busy", {31'd0, busy}, 32'd0);
    checkOutput("t1_after_gnt", {28'd0, gnt}, 32'd0);
    stepClock();

    // All four requesting: rotation A, B, C, D, A.
    doReset();
    order_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      if (gnt != 4'b0000) grant_seen.push_back(gnt);
      stepClock();
    end
    checkOutput("rr_count", 32'(grant_seen.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_order%0d", i), {28'd0, grant_seen[i]}, {28'd0, order_exp[i]});
    end

    // Locked burst from B is cut at MAX_BEATS, then A wins.
    beats_seen = 0;
    for (int i = 0; i < 1 + MAX_BEATS; i++) begin
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      if (out_valid && out_ready && gnt == 4'b0010) beats_seen++;
      stepClock();
    end
    checkOutput("burst_beats", 32'(beats_seen), 32'(MAX_BEATS));
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    checkOutput("burst_release_gnt", {28'd0, gnt}, 32'd0);
    stepClock();
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    checkOutput("burst_next_a", {28'd0, gnt}, 32'h1);
    stepClock();

    // Sink stalls for five cycles during C's grant.
    doReset();
    data_c = 16'hBEEF;
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    stepClock();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b0);
      checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_data", {16'd0, out_data}, 32'hBEEF);
      checkOutput("stall_gnt", {28'd0, gnt}, 32'h4);
      stepClock();
    end
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    checkOutput("stall_beat_gnt", {28'd0, gnt}, 32'h4);
    stepClock();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("stall_done_gnt", {28'd0, gnt}, 32'd0);
    stepClock();

    // D abandons its grant before any beat; A is next.
    doReset();
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    stepClock();
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkOutput("drop_gnt_d", {28'd0, gnt}, 32'h8);
    stepClock();
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("drop_valid", {31'd0, out_valid}, 32'd0);
    stepClock();
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("drop_idle", {28'd0, gnt}, 32'd0);
    stepClock();
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("drop_next_a", {28'd0, gnt}, 32'h1);
    stepClock();

    // Asynchronous reset in the middle of a locked burst.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0001, 4'b0001, 1'b1);
      stepClock();
    end
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("midrst_sel", {30'd0, sel}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    stepClock();
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    checkOutput("midrst_then_d", {28'd0, gnt}, 32'h8);
    stepClock();

    // Randomized traffic with sticky requests and occasional resets.
    doReset();
    cur_req = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      data_a = 16'($urandom);
      data_b = 16'($urandom);
      data_c = 16'($urandom);
      data_d = 16'($urandom);
      for (int b = 0; b < 4; b++) begin
        if (cur_req[b]) begin
          if ($urandom_range(0, 7) == 0) cur_req[b] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          cur_req[b] = 1'b1;
        end
      end
      applyStimulus(cur_req, 4'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 299) == 0) doReset();
      else stepClock();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
